mac_mat_mem_seq: RTL and testbench
==================================

// Module: mac_mat_mem_seq
// PURPOSE
//  Matrix operand/result store for the MAC datapath: register-array banks A (MxK), B (KxN), C (MxN).
//  Successor to the combinational-read store: registered reads with valid strobes, C accumulate-write
//  (read-modify-write), and a sequential C-clear engine so C can be zeroed between tiles without reset.
// PARAMETERS
//  M           4                  rows of A and C
//  K           4                  cols of A / rows of B
//  N           4                  cols of B and C
//  DW          32                 A/B element width (unsigned)
//  CW          2*DW+$clog2(K)     C element width (unsigned)
// PORTS
//  clk         in   1             clock, all state on rising edge
//  reset       in   1             synchronous, active-high
//  a_we/a_re   in   1/1           A write / read enable
//  a_row,a_col in   clog2(M),clog2(K)  A address (shared by read and write)
//  a_wdata     in   DW            A write data
//  a_rdata     out  DW            A read data (registered)
//  a_rvalid    out  1             a_rdata valid
//  b_we/b_re, b_row,b_col, b_wdata, b_rdata, b_rvalid: as A; b_row clog2(K), b_col clog2(N)
//  c_we/c_re   in   1/1           C write / read enable
//  c_acc       in   1             with c_we: 1 = C[r][c] += c_wdata, 0 = overwrite
//  c_row,c_col in   clog2(M),clog2(N)  C address
//  c_wdata     in   CW            C write/accumulate operand
//  c_rdata     out  CW            C read data (registered)
//  c_rvalid    out  1             c_rdata valid
//  clr_start   in   1             pulse: start sequential clear of C
//  clr_busy    out  1             clear in progress
//  clr_done    out  1             one-cycle pulse on clear completion
//  c_ovf       out  1             sticky accumulate overflow (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all A/B/C entries 0; every output 0; FSM -> IDLE. Reset mid-clear aborts clear, same result.
//  - Read latency 1: x_re at edge n -> x_rdata = entry, x_rvalid=1 after edge n. x_re=0 -> x_rvalid=0,
//    x_rdata holds last value. Read+write same cycle/address returns OLD value (read-before-write).
//  - A/B write: x_we -> entry written at edge; independent of each other and of the clear FSM.
//  - C accumulate: single-cycle RMW; new = old + c_wdata computed at CW bits; wrap/saturate per macro.
//    Back-to-back accumulates to same address each see the previous cycle's result (no hazard).
//  - FSM IDLE -> CLEAR on clr_start (IDLE only; ignored otherwise). CLEAR zeroes one C entry/cycle,
//    row-major (0,0)..(M-1,N-1); clr_busy=1 for exactly M*N cycles. After last entry -> DONE for one
//    cycle (clr_done=1, clr_busy=0) -> IDLE. clr_start in DONE ignored.
//  - While clr_busy: c_we, c_acc, c_re ignored; c_rvalid=0. A/B fully usable. c_ovf unaffected by clear.
//  - Out-of-range addresses (non-power-of-2 dims): writes dropped, reads return 0 with valid=1.
// CONFIGURATION
//  MAC_MEM_SAT_EN defined: accumulate saturates at 2^CW-1; any saturating accumulate sets c_ovf,
//    which stays 1 until reset.
//  MAC_MEM_SAT_EN undefined: accumulate wraps modulo 2^CW; c_ovf tied 0.
//  Overwrite writes (c_acc=0) never set c_ovf in either build.
// TESTING
//  1 Reset then a_re/b_re/c_re at every address -> rdata=0, rvalid=1 one cycle after each re.
//  2 Write A[1][2]=0xDEADBEEF; same cycle a_re same addr -> old 0; next-cycle read -> 0xDEADBEEF.
//  3 C[0][0]=5 overwrite, then c_acc with 7,7,7 on consecutive cycles -> read 26.
//  4 Fill C with 0xFF; clr_start -> clr_busy 16 cycles (M=N=4), clr_done one cycle, all C=0;
//    c_we during busy dropped; A writes during busy land; clr_start during busy ignored.
//  5 Assert reset at clear cycle 5 -> busy/done 0 next cycle, all banks 0, FSM accepts new clr_start.
//  6 C[3][3]=2^CW-2, acc 5 -> SAT_EN: 2^CW-1, c_ovf=1 sticky; no SAT_EN: 3, c_ovf=0.

Source files
------------

// File: rtl/mac_mat_mem_seq.sv
// mac_mat_mem_seq: operand/result store for the MAC datapath.
// Banks A (MxK), B (KxN) and C (MxN) are register arrays with registered reads and valid strobes.
// C supports single-cycle accumulate (read-modify-write) and a sequential clear engine
// that zeroes one C entry per cycle in row-major order.
// Optional feature: define MAC_MEM_SAT_EN to make C accumulates saturate and drive the sticky
// c_ovf flag. Without it, accumulates wrap and c_ovf is tied low.
module mac_mat_mem_seq #(
    parameter int M  = 4,
    parameter int K  = 4,
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int CW = 2*DW + $clog2(K),
    localparam int MAW = (M > 1) ? $clog2(M) : 1,
    localparam int KAW = (K > 1) ? $clog2(K) : 1,
    localparam int NAW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           a_we,
    input  logic           a_re,
    input  logic [MAW-1:0] a_row,
    input  logic [KAW-1:0] a_col,
    input  logic [DW-1:0]  a_wdata,
    output logic [DW-1:0]  a_rdata,
    output logic           a_rvalid,
    input  logic           b_we,
    input  logic           b_re,
    input  logic [KAW-1:0] b_row,
    input  logic [NAW-1:0] b_col,
    input  logic [DW-1:0]  b_wdata,
    output logic [DW-1:0]  b_rdata,
    output logic           b_rvalid,
    input  logic           c_we,
    input  logic           c_re,
    input  logic           c_acc,
    input  logic [MAW-1:0] c_row,
    input  logic [NAW-1:0] c_col,
    input  logic [CW-1:0]  c_wdata,
    output logic [CW-1:0]  c_rdata,
    output logic           c_rvalid,
    input  logic           clr_start,
    output logic           clr_busy,
    output logic           clr_done,
    output logic           c_ovf
);

    // One extra bit on the limits so the range compare also works for power-of-2 sizes.
    localparam logic [MAW:0]   M_LIM  = (MAW+1)'(M);
    localparam logic [KAW:0]   K_LIM  = (KAW+1)'(K);
    localparam logic [NAW:0]   N_LIM  = (NAW+1)'(N);
    localparam logic [MAW-1:0] M_LAST = MAW'(M - 1);
    localparam logic [NAW-1:0] N_LAST = NAW'(N - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    logic [DW-1:0] a_mem [M][K];
    logic [DW-1:0] b_mem [K][N];
    logic [CW-1:0] c_mem [M][N];

    clr_state_t    state_reg;
    logic [MAW-1:0] clr_row_reg;
    logic [NAW-1:0] clr_col_reg;

    logic          a_ok, b_ok, c_ok;
    logic          c_block;
    logic          c_wr_ok;
    logic [CW-1:0] c_old;
    logic [CW-1:0] c_new;

    assign a_ok = ({1'b0, a_row} < M_LIM) && ({1'b0, a_col} < K_LIM);
    assign b_ok = ({1'b0, b_row} < K_LIM) && ({1'b0, b_col} < N_LIM);
    assign c_ok = ({1'b0, c_row} < M_LIM) && ({1'b0, c_col} < N_LIM);

    // The user C port is locked out while clearing and on the cycle a clear is accepted,
    // so c_rvalid is never raised during a busy cycle.
    assign c_block = (state_reg == CLEAR) || ((state_reg == IDLE) && clr_start);
    assign c_wr_ok = c_we && !c_block && c_ok;
    assign c_old   = c_mem[c_row][c_col];

`ifdef MAC_MEM_SAT_EN
    logic [CW:0] acc_full;
    logic        acc_sat;

    // Accumulate with one guard bit; a carry out means the result clamps to all ones.
    always_comb begin
        acc_full = {1'b0, c_old} + {1'b0, c_wdata};
        acc_sat  = acc_full[CW];
        c_new    = c_acc ? (acc_sat ? '1 : acc_full[CW-1:0]) : c_wdata;
    end

    // Sticky overflow flag: only saturating accumulates set it, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            c_ovf <= 1'b0;
        else if (c_wr_ok && c_acc && acc_sat)
            c_ovf <= 1'b1;
    end
`else
    // Accumulate wraps modulo 2^CW.
    always_comb begin
        c_new = c_acc ? (c_old + c_wdata) : c_wdata;
    end

    assign c_ovf = 1'b0;
`endif

    // A bank: write plus registered read; the read sees the contents before this edge's write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < K; j++)
                    a_mem[i][j] <= '0;
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
        end else begin
            if (a_we && a_ok)
                a_mem[a_row][a_col] <= a_wdata;
            a_rvalid <= a_re;
            if (a_re)
                a_rdata <= a_ok ? a_mem[a_row][a_col] : '0;
        end
    end

    // B bank: same structure as A.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < N; j++)
                    b_mem[i][j] <= '0;
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
        end else begin
            if (b_we && b_ok)
                b_mem[b_row][b_col] <= b_wdata;
            b_rvalid <= b_re;
            if (b_re)
                b_rdata <= b_ok ? b_mem[b_row][b_col] : '0;
        end
    end

    // C bank: clear engine has priority, otherwise overwrite/accumulate and registered read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    c_mem[i][j] <= '0;
            c_rdata  <= '0;
            c_rvalid <= 1'b0;
        end else begin
            if (state_reg == CLEAR)
                c_mem[clr_row_reg][clr_col_reg] <= '0;
            else if (c_wr_ok)
                c_mem[c_row][c_col] <= c_new;
            c_rvalid <= c_re && !c_block;
            if (c_re && !c_block)
                c_rdata <= c_ok ? c_old : '0;
        end
    end

    // Clear FSM: IDLE -> CLEAR (M*N cycles, row-major walk) -> DONE (one cycle) -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            clr_row_reg <= '0;
            clr_col_reg <= '0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_start) begin
                        state_reg   <= CLEAR;
                        clr_row_reg <= '0;
                        clr_col_reg <= '0;
                        clr_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if ((clr_row_reg == M_LAST) && (clr_col_reg == N_LAST)) begin
                        state_reg <= DONE;
                        clr_busy  <= 1'b0;
                        clr_done  <= 1'b1;
                    end else if (clr_col_reg == N_LAST) begin
                        clr_col_reg <= '0;
                        clr_row_reg <= clr_row_reg + 1'b1;
                    end else begin
                        clr_col_reg <= clr_col_reg + 1'b1;
                    end
                end
                DONE: begin
                    clr_done  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    clr_busy  <= 1'b0;
                    clr_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_mat_mem_seq.sv
// Bench for mac_mat_mem_seq (default 4x4x4, DW=32, CW=66).
// Read expectations are queued when a read is issued and popped when the matching rvalid appears.
module tb_mac_mat_mem_seq;

    localparam int DW = 32;
    localparam int CW = 66;

    logic          clk;
    logic          reset;
    logic          a_we, a_re, b_we, b_re, c_we, c_re, c_acc, clr_start;
    logic [1:0]    a_row, a_col, b_row, b_col, c_row, c_col;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic [CW-1:0] c_wdata, c_rdata;
    logic          a_rvalid, b_rvalid, c_rvalid, clr_busy, clr_done, c_ovf;

    logic [CW-1:0] qa[$];
    logic [CW-1:0] qb[$];
    logic [CW-1:0] qc[$];
    int            total  = 0;
    int            passed = 0;
    bit            tb_busy = 0;
    int            nbusy;
    logic [CW-1:0] big;

    mac_mat_mem_seq dut (
        .clk(clk), .reset(reset),
        .a_we(a_we), .a_re(a_re), .a_row(a_row), .a_col(a_col), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_we(b_we), .b_re(b_re), .b_row(b_row), .b_col(b_col), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .c_we(c_we), .c_re(c_re), .c_acc(c_acc), .c_row(c_row), .c_col(c_col),
        .c_wdata(c_wdata), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .c_ovf(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        a_we = 0; a_re = 0; b_we = 0; b_re = 0; c_we = 0; c_re = 0; c_acc = 0; clr_start = 0;
    endtask

    // Advance one edge, then check every valid strobe and pop the matching expectation.
    task automatic tick();
        logic ar, br, cr;
        ar = a_re; br = b_re; cr = c_re && !tb_busy;
        @(posedge clk); #1;
        chk("a_rvalid", CW'(a_rvalid), CW'(ar));
        if (ar && qa.size() > 0) chk("a_rdata", CW'(a_rdata), qa.pop_front());
        chk("b_rvalid", CW'(b_rvalid), CW'(br));
        if (br && qb.size() > 0) chk("b_rdata", CW'(b_rdata), qb.pop_front());
        chk("c_rvalid", CW'(c_rvalid), CW'(cr));
        if (cr && qc.size() > 0) chk("c_rdata", c_rdata, qc.pop_front());
    endtask

    task automatic rd_a(input int r, input int c, input logic [CW-1:0] e);
        a_re = 1; a_row = r[1:0]; a_col = c[1:0]; qa.push_back(e);
    endtask
    task automatic rd_b(input int r, input int c, input logic [CW-1:0] e);
        b_re = 1; b_row = r[1:0]; b_col = c[1:0]; qb.push_back(e);
    endtask
    task automatic rd_c(input int r, input int c, input logic [CW-1:0] e);
        c_re = 1; c_row = r[1:0]; c_col = c[1:0]; qc.push_back(e);
    endtask
    task automatic wr_c(input int r, input int c, input logic acc, input logic [CW-1:0] d);
        c_we = 1; c_acc = acc; c_row = r[1:0]; c_col = c[1:0]; c_wdata = d;
    endtask

    // Start a clear and count busy cycles; optionally disturb the C port and A bank mid-clear.
    task automatic run_clear(input bit disturb, output int n);
        clr_start = 1; tick(); idle();
        tb_busy = 1;
        chk("busy_start", CW'(clr_busy), CW'(1));
        n = 0;
        while (clr_busy === 1'b1 && n < 40) begin
            n++;
            if (disturb && n == 5) begin
                wr_c(0, 0, 1'b0, CW'(32'h99));
                c_re = 1; c_row = 2'd1; c_col = 2'd1;
                a_we = 1; a_row = 2'd3; a_col = 2'd3; a_wdata = 32'hA5A5_0001;
                clr_start = 1;
            end
            tick(); idle();
        end
        tb_busy = 0;
        chk("busy_len", CW'(n), CW'(16));
        chk("done_pulse", CW'(clr_done), CW'(1));
        chk("busy_end", CW'(clr_busy), CW'(0));
    endtask

    initial begin
        idle();
        reset = 1;
        a_row = 0; a_col = 0; b_row = 0; b_col = 0; c_row = 0; c_col = 0;
        a_wdata = 0; b_wdata = 0; c_wdata = 0;
        big = '1;
        @(negedge clk);
        tick(); tick();
        chk("rst_a_rdata", CW'(a_rdata), '0);
        chk("rst_b_rdata", CW'(b_rdata), '0);
        chk("rst_c_rdata", c_rdata, '0);
        chk("rst_busy", CW'(clr_busy), '0);
        chk("rst_done", CW'(clr_done), '0);
        chk("rst_ovf", CW'(c_ovf), '0);
        reset = 0;

        // Every address of every bank reads zero after reset.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                rd_a(r, c, '0); rd_b(r, c, '0); rd_c(r, c, '0);
                tick(); idle();
            end
        tick();

        // Read-before-write on A, then the new value, then rdata holds with re low.
        a_we = 1; a_row = 2'd1; a_col = 2'd2; a_wdata = 32'hDEADBEEF;
        rd_a(1, 2, '0);
        tick(); idle();
        rd_a(1, 2, CW'(32'hDEADBEEF));
        tick(); idle();
        tick();
        chk("a_rdata_hold", CW'(a_rdata), CW'(32'hDEADBEEF));
        b_we = 1; b_row = 2'd2; b_col = 2'd3; b_wdata = 32'h1234_5678;
        tick(); idle();
        rd_b(2, 3, CW'(32'h1234_5678));
        tick(); idle();

        // Overwrite then three back-to-back accumulates to the same entry.
        wr_c(0, 0, 1'b0, CW'(5)); tick(); idle();
        for (int i = 0; i < 3; i++) begin
            wr_c(0, 0, 1'b1, CW'(7)); tick(); idle();
        end
        rd_c(0, 0, CW'(26)); tick(); idle();

        // Fill C, then clear it with disturbances mid-clear.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                wr_c(r, c, 1'b0, CW'(8'hFF)); tick(); idle();
            end
        rd_c(2, 1, CW'(8'hFF)); tick(); idle();
        run_clear(1'b1, nbusy);
        clr_start = 1; tick(); idle();
        chk("start_in_done_ignored", CW'(clr_busy), '0);
        chk("done_one_cycle", CW'(clr_done), '0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                rd_c(r, c, '0); tick(); idle();
            end
        rd_a(3, 3, CW'(32'hA5A5_0001)); tick(); idle();

        // Reset in the middle of a clear.
        wr_c(1, 1, 1'b0, CW'(8'h33)); tick(); idle();
        clr_start = 1; tick(); idle();
        tb_busy = 1;
        for (int i = 0; i < 4; i++) tick();
        reset = 1; tick();
        tb_busy = 0;
        chk("rst_mid_busy", CW'(clr_busy), '0);
        chk("rst_mid_done", CW'(clr_done), '0);
        reset = 0;
        rd_a(1, 2, '0); rd_b(2, 3, '0); rd_c(1, 1, '0); tick(); idle();
        rd_c(3, 3, '0); tick(); idle();
        run_clear(1'b0, nbusy);
        tick();
        chk("ovf_before_sat", CW'(c_ovf), '0);

        // Accumulate past the top of the C range.
        wr_c(3, 3, 1'b0, big - CW'(1)); tick(); idle();
        wr_c(3, 3, 1'b1, CW'(5)); tick(); idle();
`ifdef MAC_MEM_SAT_EN
        rd_c(3, 3, big); tick(); idle();
        chk("ovf_set", CW'(c_ovf), CW'(1));
        wr_c(3, 3, 1'b0, CW'(1)); tick(); idle();
        rd_c(3, 3, CW'(1)); tick(); idle();
        chk("ovf_sticky", CW'(c_ovf), CW'(1));
`else
        rd_c(3, 3, CW'(3)); tick(); idle();
        chk("ovf_wrap", CW'(c_ovf), '0);
        wr_c(3, 3, 1'b1, CW'(10)); tick(); idle();
        rd_c(3, 3, CW'(13)); tick(); idle();
        chk("ovf_still_0", CW'(c_ovf), '0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
